// File: rtl/cam_pkg.sv
// Shared types and constants for the security-monitor camera view controller.
package cam_pkg;

    localparam int unsigned NUM_CAMS      = 6;
    localparam int unsigned CAM_W         = 3;
    localparam int unsigned WORDS_PER_CAM = 57600;
    localparam int unsigned ADDR_W        = 19;

    localparam logic [CAM_W-1:0] CAM_HALLWAY = 3'd0;
    localparam logic [CAM_W-1:0] CAM_LAB     = 3'd1;
    localparam logic [CAM_W-1:0] CAM_STORAGE = 3'd2;
    localparam logic [CAM_W-1:0] CAM_VENTS   = 3'd3;
    localparam logic [CAM_W-1:0] CAM_OFFICE  = 3'd4;
    localparam logic [CAM_W-1:0] CAM_EXIT    = 3'd5;

    typedef enum logic [2:0] {
        StIdle,
        StOpen,
        StShow,
        StPend,
        StSwitch
    } cam_state_e;

    // Largest base is 5*57600 = 288000, which fits in ADDR_W bits without wrapping.
    function automatic logic [ADDR_W-1:0] cam_base(input logic [CAM_W-1:0] id);
        return ADDR_W'(id) * ADDR_W'(WORDS_PER_CAM);
    endfunction

endpackage

// File: rtl/static_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) producing per-pixel static intensity.
module static_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    output logic [3:0] level_o
);

    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  level_q;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // Level has its own register so it can reset to zero independently of the seed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q  <= SEED;
            level_q <= 4'd0;
        end else if (en_i) begin
            lfsr_q  <= lfsr_d;
            level_q <= lfsr_d[3:0];
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/cam_view_ctrl.sv
// Camera-feed sequencer: applies camera switches on frame boundaries with static frames.
module cam_view_ctrl
    import cam_pkg::*;
#(
    parameter int unsigned STATIC_FRAMES = 4,
    parameter int unsigned OPEN_FRAMES   = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic              vga_clk_i,
    input  logic              reset_i,
    input  logic              frame_start_i,
    input  logic              monitor_up_i,
    input  logic              req_valid_i,
    input  logic [CAM_W-1:0]  req_id_i,
    output logic              req_ready_o,
    output logic [CAM_W-1:0]  cam_sel_o,
    output logic [ADDR_W-1:0] rom_base_o,
    output logic              static_en_o,
    output logic [3:0]        static_level_o,
    output logic              busy_o,
    output logic              req_err_o
);

    if (OPEN_FRAMES > 15 || OPEN_FRAMES < 1 || STATIC_FRAMES > 15 || STATIC_FRAMES < 1)
    begin : g_frames_bad
        $error("cam_view_ctrl: OPEN_FRAMES and STATIC_FRAMES must be in 1..15");
    end

    localparam logic [3:0] OpenLast   = 4'(OPEN_FRAMES);
    localparam logic [3:0] SwitchLast = 4'(STATIC_FRAMES);

    cam_state_e        state_q;
    logic [CAM_W-1:0]  cam_sel_q, pend_q;
    logic [ADDR_W-1:0] rom_base_q;
    logic              static_en_q, req_ready_q, busy_q, req_err_q, arm_q;
    logic [3:0]        cnt_q, cnt_inc;
    logic              hs;

    always_comb begin
        cnt_inc = (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;
        hs      = req_valid_i && req_ready_q;
    end

    always_ff @(posedge vga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            cam_sel_q   <= '0;
            rom_base_q  <= '0;
            static_en_q <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            req_err_q   <= 1'b0;
            cnt_q       <= 4'd0;
            pend_q      <= '0;
            arm_q       <= 1'b0;
        end else begin
            req_err_q <= 1'b0;
            // Monitor drop overrides every other event, including frame_start.
            if (state_q != StIdle && !monitor_up_i) begin
                state_q     <= StIdle;
                static_en_q <= 1'b0;
                req_ready_q <= 1'b0;
                busy_q      <= 1'b1;
                cnt_q       <= 4'd0;
                pend_q      <= '0;
                arm_q       <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (monitor_up_i) arm_q <= 1'b1;
                        if (frame_start_i && (arm_q || monitor_up_i)) begin
                            state_q     <= StOpen;
                            static_en_q <= 1'b1;
                            cnt_q       <= 4'd0;
                            arm_q       <= 1'b0;
                        end
                    end
                    StOpen: begin
                        if (frame_start_i) begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc == OpenLast) begin
                                state_q     <= StShow;
                                static_en_q <= 1'b0;
                                req_ready_q <= 1'b1;
                                busy_q      <= 1'b0;
                            end
                        end
                    end
                    StShow: begin
                        if (hs) begin
                            if (32'(req_id_i) >= NUM_CAMS) begin
                                req_err_q <= 1'b1;
                            end else if (req_id_i != cam_sel_q) begin
                                pend_q      <= req_id_i;
                                state_q     <= StPend;
                                req_ready_q <= 1'b0;
                                busy_q      <= 1'b1;
                            end
                        end
                    end
                    StPend: begin
                        if (frame_start_i) begin
                            cam_sel_q   <= pend_q;
                            rom_base_q  <= cam_base(pend_q);
                            static_en_q <= 1'b1;
                            cnt_q       <= 4'd0;
                            state_q     <= StSwitch;
                        end
                    end
                    StSwitch: begin
                        if (frame_start_i) begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc == SwitchLast) begin
                                state_q     <= StShow;
                                static_en_q <= 1'b0;
                                req_ready_q <= 1'b1;
                                busy_q      <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    static_lfsr #(
        .SEED (LFSR_SEED)
    ) u_static_lfsr (
        .clk_i   (vga_clk_i),
        .rst_i   (reset_i),
        .en_i    (static_en_q),
        .level_o (static_level_o)
    );

    assign req_ready_o = req_ready_q;
    assign cam_sel_o   = cam_sel_q;
    assign rom_base_o  = rom_base_q;
    assign static_en_o = static_en_q;
    assign busy_o      = busy_q;
    assign req_err_o   = req_err_q;

endmodule

// File: tb/tb_cam_view_ctrl.sv
// Directed self-checking bench for cam_view_ctrl.
module tb_cam_view_ctrl;

    localparam int unsigned Gap = 800;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        monitor_up;
    logic        req_valid;
    logic [2:0]  req_id;
    logic        req_ready;
    logic [2:0]  cam_sel;
    logic [18:0] rom_base;
    logic        static_en;
    logic [3:0]  static_level;
    logic        busy;
    logic        req_err;

    int n_tests = 0;
    int n_fail  = 0;

    cam_view_ctrl u_dut (
        .vga_clk_i      (vga_clk),
        .reset_i        (reset),
        .frame_start_i  (frame_start),
        .monitor_up_i   (monitor_up),
        .req_valid_i    (req_valid),
        .req_id_i       (req_id),
        .req_ready_o    (req_ready),
        .cam_sel_o      (cam_sel),
        .rom_base_o     (rom_base),
        .static_en_o    (static_en),
        .static_level_o (static_level),
        .busy_o         (busy),
        .req_err_o      (req_err)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic fs_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic request(input logic [2:0] id);
        req_valid = 1'b1;
        req_id    = id;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; monitor_up = 1'b0; req_valid = 1'b0; req_id = 3'd0;
        idle(2);
        chk("rst_cam_sel", 32'(cam_sel), 32'd0);
        chk("rst_rom_base", 32'(rom_base), 32'd0);
        chk("rst_static_en", 32'(static_en), 32'd0);
        chk("rst_level", 32'(static_level), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_err", 32'(req_err), 32'd0);
        reset = 1'b0;

        // Open: 8 static frames, then SHOW on camera 0
        idle(10);
        monitor_up = 1'b1;
        idle(20);
        chk("idle_wait_static", 32'(static_en), 32'd0);
        fs_pulse();
        chk("open_static_en", 32'(static_en), 32'd1);
        chk("open_level0", 32'(static_level), 32'd0);
        chk("open_busy", 32'(busy), 32'd1);
        tick();
        chk("lfsr_step1", 32'(static_level), 32'h3);
        tick();
        chk("lfsr_step2", 32'(static_level), 32'h7);
        tick();
        chk("lfsr_step3", 32'(static_level), 32'hF);
        tick();
        chk("lfsr_step4", 32'(static_level), 32'hE);
        idle(Gap - 4);
        for (int i = 1; i <= 7; i++) begin
            fs_pulse();
            idle(Gap);
        end
        chk("open_frame7_static", 32'(static_en), 32'd1);
        chk("open_frame7_ready", 32'(req_ready), 32'd0);
        fs_pulse();
        chk("show_static_off", 32'(static_en), 32'd0);
        chk("show_ready", 32'(req_ready), 32'd1);
        chk("show_busy", 32'(busy), 32'd0);
        chk("show_cam0", 32'(cam_sel), 32'd0);

        // Switch to camera 3
        idle(5);
        request(3'd3);
        chk("pend_ready", 32'(req_ready), 32'd0);
        chk("pend_busy", 32'(busy), 32'd1);
        chk("pend_static", 32'(static_en), 32'd0);
        idle(10);
        chk("pend_cam_hold", 32'(cam_sel), 32'd0);
        fs_pulse();
        chk("sw3_cam", 32'(cam_sel), 32'd3);
        chk("sw3_rom", 32'(rom_base), 32'd172800);
        chk("sw3_static", 32'(static_en), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            idle(Gap);
            fs_pulse();
        end
        chk("sw3_frame3_static", 32'(static_en), 32'd1);
        chk("sw3_frame3_ready", 32'(req_ready), 32'd0);
        idle(Gap);
        fs_pulse();
        chk("sw3_done_static", 32'(static_en), 32'd0);
        chk("sw3_done_ready", 32'(req_ready), 32'd1);

        // Invalid id and same-camera requests
        idle(3);
        request(3'd7);
        chk("err7_pulse", 32'(req_err), 32'd1);
        chk("err7_ready", 32'(req_ready), 32'd1);
        tick();
        chk("err7_one_cycle", 32'(req_err), 32'd0);
        request(3'd3);
        chk("same_no_err", 32'(req_err), 32'd0);
        chk("same_ready", 32'(req_ready), 32'd1);
        idle(Gap);
        fs_pulse();
        chk("same_no_static", 32'(static_en), 32'd0);
        chk("same_cam", 32'(cam_sel), 32'd3);

        // Handshake coincident with frame_start
        idle(Gap);
        frame_start = 1'b1;
        request(3'd5);
        frame_start = 1'b0;
        chk("coin_cam_hold", 32'(cam_sel), 32'd3);
        chk("coin_static", 32'(static_en), 32'd0);
        chk("coin_ready", 32'(req_ready), 32'd0);
        idle(Gap);
        fs_pulse();
        chk("coin_cam5", 32'(cam_sel), 32'd5);
        chk("coin_rom5", 32'(rom_base), 32'd288000);
        for (int i = 1; i <= 4; i++) begin
            idle(Gap);
            fs_pulse();
        end
        chk("coin_show", 32'(req_ready), 32'd1);

        // Monitor drop during PEND
        idle(3);
        request(3'd1);
        tick();
        monitor_up = 1'b0;
        tick();
        chk("drop_static", 32'(static_en), 32'd0);
        chk("drop_cam", 32'(cam_sel), 32'd5);
        chk("drop_busy", 32'(busy), 32'd1);
        idle(Gap);
        fs_pulse();
        chk("drop_no_switch", 32'(cam_sel), 32'd5);
        chk("drop_stay_idle", 32'(static_en), 32'd0);
        monitor_up = 1'b1;
        tick();
        fs_pulse();
        chk("reopen_static", 32'(static_en), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            idle(Gap);
            fs_pulse();
        end
        chk("reopen_cam", 32'(cam_sel), 32'd5);
        chk("reopen_rom", 32'(rom_base), 32'd288000);
        chk("reopen_ready", 32'(req_ready), 32'd1);

        // Asynchronous reset mid-SWITCH
        request(3'd2);
        idle(Gap);
        fs_pulse();
        chk("presw_cam2", 32'(cam_sel), 32'd2);
        chk("presw_rom2", 32'(rom_base), 32'd115200);
        idle(3);
        #2 reset = 1'b1;
        #1;
        chk("arst_cam", 32'(cam_sel), 32'd0);
        chk("arst_rom", 32'(rom_base), 32'd0);
        chk("arst_static", 32'(static_en), 32'd0);
        chk("arst_level", 32'(static_level), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd0);
        chk("arst_busy", 32'(busy), 32'd1);
        tick();
        reset = 1'b0;
        tick();
        fs_pulse();
        chk("post_rst_open", 32'(static_en), 32'd1);
        chk("post_rst_cam", 32'(cam_sel), 32'd0);
        tick();
        chk("post_rst_seed", 32'(static_level), 32'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
